// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path: FSM state encoding,
// byte width and drop-counter width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CHK  = 2'd2
  } state_e;

  localparam int BYTE_W     = 8;
  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/alu_result_sender.sv
// Captures one ALU result at a time and streams it LSB-byte-first to the UART TX FIFO.
// Optional trailing XOR checksum byte when ALU_SENDER_CHKSUM_EN is defined.
module alu_result_sender
  import alu_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OUT_WIDTH-1:0]  alu_out,
  input  logic                  alu_valid,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  drop_clr
);

  localparam int NBYTES = OUT_WIDTH / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // tx_valid never drops and tx_data never changes until that transfer happens.
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [OUT_WIDTH-1:0]    hold_q, hold_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    busy_q, busy_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic                    accept;
  logic [BYTE_W-1:0]       data_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign accept    = tx_valid_q && tx_ready;
  assign data_byte = hold_q[{idx_q, 3'b000} +: BYTE_W];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (alu_valid) begin
          hold_d     = alu_out;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
`ifdef ALU_SENDER_CHKSUM_EN
            state_d    = CHK;
`else
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            idx_d      = '0;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef ALU_SENDER_CHKSUM_EN
      CHK: begin
        if (accept) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          idx_d      = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // A result arriving while a frame is in flight (including its final accept edge) is dropped.
  always_comb begin
    drop_d = drop_q;
    if (drop_clr) begin
      drop_d = '0;
    end else if (alu_valid && busy_q && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

`ifdef ALU_SENDER_CHKSUM_EN
  logic [BYTE_W-1:0] chk_byte;

  always_comb begin
    chk_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      chk_byte = chk_byte ^ hold_q[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    tx_data = '0;
    if (tx_valid_q) begin
      tx_data = (state_q == CHK) ? chk_byte : data_byte;
    end
  end
`else
  assign tx_data = tx_valid_q ? data_byte : '0;
`endif

  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_alu_result_sender.sv
// Randomized and directed bench for alu_result_sender against a frame-queue model.
module tb_alu_result_sender;

  localparam int OUT_W  = 16;
  localparam int NBYTES = OUT_W / 8;

  logic             clk;
  logic             rst;
  logic [OUT_W-1:0] alu_out;
  logic             alu_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic [7:0]       drop_cnt;
  logic             drop_clr;

  int checks = 0;
  int errors = 0;

  // Bytes still owed by the frame in flight; empty means idle.
  logic [7:0] exp_q[$];
  int         exp_drop = 0;

  alu_result_sender #(.OUT_WIDTH(OUT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_out  (alu_out),
    .alu_valid(alu_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .drop_clr (drop_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [OUT_W-1:0] v);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      exp_q.push_back(v[8*i +: 8]);
      x = x ^ v[8*i +: 8];
    end
`ifdef ALU_SENDER_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic compare();
    check("tx_valid", 64'(tx_valid), 64'(exp_q.size() != 0));
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    if (exp_q.size() != 0) check("tx_data", 64'(tx_data), 64'(exp_q[0]));
  endtask

  // Called at a negedge; inputs stay stable across the following posedge.
  task automatic step(input logic v, input logic [OUT_W-1:0] d, input logic rdy, input logic clr);
    logic was_busy;
    alu_valid = v;
    alu_out   = d;
    tx_ready  = rdy;
    drop_clr  = clr;
    @(posedge clk);
    was_busy = (exp_q.size() != 0);
    if (was_busy && rdy) void'(exp_q.pop_front());
    if (!was_busy && v) push_frame(d);
    if (clr) exp_drop = 0;
    else if (was_busy && v && exp_drop < 255) exp_drop++;
    @(negedge clk);
    compare();
  endtask

  task automatic reset_mid_cycle();
    alu_valid = 1'b0;
    tx_ready  = 1'b0;
    drop_clr  = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    exp_q.delete();
    exp_drop = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [OUT_W-1:0] rand_data();
    return OUT_W'({$urandom, $urandom});
  endfunction

  initial begin
    rst       = 1'b0;
    alu_out   = '0;
    alu_valid = 1'b0;
    tx_ready  = 1'b0;
    drop_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx_valid", 64'(tx_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_tx_data", 64'(tx_data), 64'(0));
    check("reset_drop_cnt", 64'(drop_cnt), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Basic frame, ready high.
    step(1'b1, 16'hA55A, 1'b1, 1'b0);
    check("first_byte", 64'(tx_data), 64'h5A);
    step(1'b0, '0, 1'b1, 1'b0);
    check("second_byte", 64'(tx_data), 64'hA5);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Stall on byte 1 for three cycles.
    step(1'b1, 16'hA55A, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    repeat (3) begin
      step(1'b0, '0, 1'b0, 1'b0);
      check("stall_byte", 64'(tx_data), 64'hA5);
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // Drop during a stalled frame.
    step(1'b1, 16'hA55A, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    check("drop_one", 64'(drop_cnt), 64'd1);
    check("drop_keeps_byte", 64'(tx_data), 64'h5A);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Saturation then clear-wins.
    step(1'b1, 16'h0BAD, 1'b0, 1'b0);
    repeat (300) step(1'b1, rand_data(), 1'b0, 1'b0);
    check("drop_sat", 64'(drop_cnt), 64'd255);
    step(1'b1, rand_data(), 1'b0, 1'b1);
    check("drop_clr_wins", 64'(drop_cnt), 64'd0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Reset after byte 0 accepted, then a fresh frame.
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    reset_mid_cycle();
    step(1'b1, 16'h00FF, 1'b1, 1'b0);
    check("post_rst_byte0", 64'(tx_data), 64'hFF);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_byte1", 64'(tx_data), 64'h00);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) == 0, rand_data(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
